// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared constants for the bit-serial subtractor.
//   - FSM state encoding (2-bit): StIdle, StRun, StDone
//   - DefaultWidth: default operand/result width
//   - cnt_width(): bit counter width for a given operand width
package serial_sub_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam int unsigned DefaultWidth = 8;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake bundle for serial_subtractor.
// Optional macro: SERIAL_SUB_OVF_EN adds the ovf signal.
//   in_valid/in_ready/a/b : operand side (producer -> block)
//   out_valid/out_ready   : result side (block -> consumer)
//   diff/borrow/zero/ovf  : result fields, meaningful while out_valid
// Modports: master = producer/consumer side, slave = subtractor side.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/full_subtractor.sv
// full_subtractor: gate-level one-bit full subtractor cell (a - b - bin).
//   a, b : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
    input  wire a,
    input  wire b,
    input  wire bin,
    output wire d,
    output wire bout
);
    wire a_n;
    wire t_ab;
    wire t_abin;
    wire t_bbin;

    xor u_xor_d   (d, a, b, bin);
    not u_not_a   (a_n, a);
    and u_and_ab  (t_ab, a_n, b);
    and u_and_ai  (t_abin, a_n, bin);
    and u_and_bi  (t_bbin, b, bin);
    or  u_or_bout (bout, t_ab, t_abin, t_bbin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = (a - b) mod 2^WIDTH,
// one bit per clock LSB first through a single full_subtractor cell.
// Optional macro: SERIAL_SUB_OVF_EN adds the signed-overflow output and its
// sign-capture flops.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : serial_subtractor_if.slave (operand/result handshakes and result fields)
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bin_q, bin_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Result fills from the MSB side so bit 0 ends up at res_q[0].
                res_d = {cell_d, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = cell_bout;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode only from the state register.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.diff      = res_q;
    assign bus.borrow    = bin_q;
    assign bus.zero      = (state_q == StDone) && (res_q == '0);

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep copies from accept.
    logic sa_q, sa_d;
    logic sb_q, sb_d;

    always_comb begin
        sa_d = sa_q;
        sb_d = sb_q;
        if (state_q == StIdle && bus.in_valid) begin
            sa_d = bus.a[WIDTH-1];
            sb_d = bus.b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q <= 1'b0;
            sb_q <= 1'b0;
        end else begin
            sa_q <= sa_d;
            sb_q <= sb_d;
        end
    end

    assign bus.ovf = (state_q == StDone) && (sa_q != sb_q) && (res_q[WIDTH-1] != sa_q);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// against an arithmetic reference model. Build with SERIAL_SUB_OVF_EN to cover ovf.
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 8;
    localparam int NumRand = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an op is accepted in idle, takes WIDTH cycles, then waits
    // for out_ready. Expected fields come straight from integer arithmetic.
    bit               m_known = 1'b0;
    bit               m_idle = 1'b1;
    bit               m_done = 1'b0;
    bit               m_acc = 1'b0;
    bit               m_rst_seen = 1'b0;
    int               m_left = 0;
    int               m_completed = 0;
    int               dut_hs = 0;
    logic [WIDTH-1:0] m_diff;
    logic             m_borrow;
    logic             m_zero;
    logic             m_ovf;

    always @(negedge clk) begin
        int sa;
        int sb;
        int r;
        if (m_known) begin
            check("in_ready", 32'(bus.in_ready), 32'(m_idle));
            check("out_valid", 32'(bus.out_valid), 32'(m_done));
            if (m_done) begin
                check("diff", 32'(bus.diff), 32'(m_diff));
                check("borrow", 32'(bus.borrow), 32'(m_borrow));
                check("zero", 32'(bus.zero), 32'(m_zero));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
            end
`ifdef SERIAL_SUB_OVF_EN
            else begin
                check("ovf_quiet", 32'(bus.ovf), 32'd0);
            end
`endif
            if (m_rst_seen) begin
                check("rst_diff", 32'(bus.diff), 32'd0);
                check("rst_borrow", 32'(bus.borrow), 32'd0);
                check("rst_zero", 32'(bus.zero), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
                check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
            end
            if (!rst && bus.out_valid && bus.out_ready) dut_hs++;
        end
        m_acc = 1'b0;
        m_rst_seen = 1'b0;
        if (rst) begin
            m_known = 1'b1;
            m_idle = 1'b1;
            m_done = 1'b0;
            m_left = 0;
            m_rst_seen = 1'b1;
        end else if (m_known) begin
            if (m_idle) begin
                if (bus.in_valid) begin
                    m_acc = 1'b1;
                    m_idle = 1'b0;
                    m_left = WIDTH;
                    m_diff = bus.a - bus.b;
                    m_borrow = (bus.a < bus.b);
                    m_zero = (m_diff == '0);
                    sa = int'($signed(bus.a));
                    sb = int'($signed(bus.b));
                    r = sa - sb;
                    m_ovf = (r < -(2 ** (WIDTH - 1))) || (r > (2 ** (WIDTH - 1)) - 1);
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (m_done && bus.out_ready) begin
                m_done = 1'b0;
                m_idle = 1'b1;
                m_completed++;
            end
        end
    end

    // Runs one op with literal expectations; leaves the block holding in DONE.
    task automatic op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] ed,
                      input logic eb, input logic ez, input bit noise);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_before_op", 32'(bus.in_ready), 32'd1);
        bus.a = ta;
        bus.b = tb_v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.a = WIDTH'($urandom);
                bus.b = WIDTH'($urandom);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            n++;
        end
        check("latency", 32'(n), 32'(WIDTH));
        check("op_diff", 32'(bus.diff), 32'(ed));
        check("op_borrow", 32'(bus.borrow), 32'(eb));
        check("op_zero", 32'(bus.zero), 32'(ez));
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("ready_after_release", 32'(bus.in_ready), 32'd1);
        check("valid_after_release", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int cyc;
        int base;
        bit pending;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        op(8'd5, 8'd3, 8'h02, 1'b0, 1'b0, 1'b0);
        release_out();
        op(8'd3, 8'd5, 8'hFE, 1'b1, 1'b0, 1'b0);
        release_out();
        op(8'd0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        release_out();

        // Backpressure with new operands offered during RUN and DONE.
        op(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b1);
        repeat (20) begin
            bus.in_valid = 1'b1;
            bus.a = WIDTH'($urandom);
            bus.b = WIDTH'($urandom);
            @(posedge clk); #1;
            check("hold_diff", 32'(bus.diff), 32'h05);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        release_out();

        // Reset while bit 4 is being processed.
        bus.a = 8'h33;
        bus.b = 8'h11;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_diff", 32'(bus.diff), 32'd0);
        op(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
        release_out();

`ifdef SERIAL_SUB_OVF_EN
        op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(bus.ovf), 32'd1);
        release_out();
        op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
        check("ovf_clear", 32'(bus.ovf), 32'd0);
        release_out();
`endif

        // Randomized back-to-back traffic with random consumer stalls.
        base = m_completed;
        issued = 0;
        cyc = 0;
        pending = 1'b0;
        while ((m_completed - base) < NumRand && cyc < 60000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!pending && issued < NumRand && $urandom_range(0, 3) != 0) begin
                bus.a = WIDTH'($urandom);
                bus.b = WIDTH'($urandom);
                if ($urandom_range(0, 7) == 0) bus.b = bus.a;
                bus.in_valid = 1'b1;
                pending = 1'b1;
            end
            @(posedge clk); #1;
            if (pending && m_acc) begin
                pending = 1'b0;
                bus.in_valid = 1'b0;
                issued++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("rand_ops_done", 32'(m_completed - base), 32'(NumRand));
        check("rand_issued", 32'(issued), 32'(NumRand));
        @(negedge clk);
        check("handshake_count", 32'(dut_hs), 32'(m_completed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b` one bit per clock through a single full-subtractor cell and a registered borrow. It is the inverse-operation companion to the team's gate-level full adder. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Area is traded for latency: one cell plus shift registers instead of an N-bit ripple chain.

## Interface
Parameters:
- `WIDTH`, 8, operand and result width in bits; must be ≥ 2.

Ports:
- `clk`  input  1  rising-edge clock, the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  producer has operands on `a`/`b`.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  minuend.
- `b`  input  WIDTH  subtrahend.
- `out_valid`  output  1  result is valid and held.
- `out_ready`  input  1  consumer accepts the result.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow`  output  1  final borrow-out; 1 iff `a < b` (unsigned).
- `zero`  output  1  1 iff `diff == 0`.
- `ovf`  output  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`: latch `a` and `b` into shift registers, clear the borrow flop and bit counter, go to RUN.
- RUN, one cycle per bit, LSB first:
  - `d = a0 ^ b0 ^ bin`.
  - `bout = (~a0 & b0) | (~a0 & bin) | (b0 & bin)`.
  - Shift `d` into the result register from the MSB side and shift both operand registers right.
  - `bin <= bout`; counter increments.
  - After bit `WIDTH-1`, go to DONE.
- DONE:
  - `out_valid=1`; `diff`, `borrow`, `zero` (and `ovf`) are stable.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored. `a`/`b` are sampled only at the accept edge.
- `zero` is computed from the final result register, not accumulated.

## Timing
- Reset values, with `rst` sampled high on a rising edge: state IDLE; `in_ready=1`; `out_valid=0`; `diff=0`; `borrow=0`; `zero=0`; `ovf=0`.
- Reset mid-RUN or mid-DONE aborts the operation with no output. Reset has priority over every handshake.
- Latency: accept at edge T, so RUN occupies cycles T..T+WIDTH-1 and `out_valid` rises after edge T+WIDTH.
- Throughput: one operation per WIDTH+2 cycles at best. `in_ready` reasserts the cycle after the output handshake.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`. Both ready/valid outputs decode directly from the state register.
- Backpressure: DONE holds indefinitely with outputs unchanged while `out_ready=0`.
- `out_ready` outside DONE has no effect.

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - `ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`, using operand sign bits captured at accept.
  - Valid with `out_valid`; 0 in IDLE and RUN.
- Undefined: no `ovf` port, no sign-capture flops. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg` holds:
  - the state encoding constants IDLE/RUN/DONE (2-bit);
  - the default width constant;
  - the counter-width helper (clog2 of WIDTH).
- Sub-module `full_subtractor`: combinational gate-level cell with ports `a`, `b`, `bin`, `d`, `bout`, built from xor/and/or primitives in the same style as the full adder. Instantiated once.
- The top level holds the FSM, counter, shift registers and borrow flop.

## Test plan
- Basic subtraction, WIDTH=8: a=5, b=3 → after 8 RUN cycles `diff=8'h02`, `borrow=0`, `zero=0`, `out_valid` exactly 8 cycles after accept.
- Negative result: a=3, b=5 → `diff=8'hFE`, `borrow=1`. Also a=0, b=0 → `diff=0`, `zero=1`, `borrow=0`.
- Backpressure and ignored input: hold `out_ready=0` for 20 cycles → outputs are stable. Pulse `in_valid` with new operands during RUN/DONE → ignored. Release `out_ready` → IDLE next cycle, `in_ready=1`.
- Reset mid-operation: assert `rst` at RUN bit 4 → next cycle IDLE, `out_valid=0`, `diff=0`. A new op a=8'hFF, b=8'h01 then gives `diff=8'hFE`.
- Overflow, with `SERIAL_SUB_OVF_EN` defined: a=8'h80, b=8'h01 → `diff=8'h7F`, `ovf=1`. a=8'h10, b=8'h01 → `ovf=0`.
- Randomized back-to-back: 1000 ops against a `(a-b)` reference with random `out_ready` → all fields match and no handshake is lost or duplicated.
